random_seq_checker: RTL and testbench
=====================================

// Module: random_seq_checker
// PURPOSE
//  Sits directly downstream of the 4-bit random sequence counter and monitors its count output.
//  Locks onto the fixed cycle 0-2-5-3-6-8-4-1-9-13-12-0 and flags every deviation.
//  Counts errors and completed sequence laps.
//  Used as a self-check on hardware and as a bench scoreboard.
// PARAMETERS
//  LOCK_N    3   consecutive correct samples needed to go from SYNC to LOCKED
//  UNLOCK_N  2   consecutive mismatches in LOCKED that drop back to HUNT
//  ERR_W     8   width of err_count (saturating)
//  LAP_W     16  width of lap_count (saturating)
// PORTS
//  clk         in   1      rising-edge clock, shared with the counter
//  reset       in   1      synchronous, active-low (reset==0 clears all state on the clk edge)
//  en          in   1      sample strobe; count_in is evaluated only when en==1
//  count_in    in   4      value from the upstream counter
//  locked      out  1      1 while FSM is in LOCKED
//  seq_err     out  1      one-cycle pulse, mismatch detected in LOCKED
//  err_count   out  ERR_W  total mismatches seen in LOCKED, saturates at all-ones
//  lap_count   out  LAP_W  matched samples of value 12 in LOCKED, saturates at all-ones
//  expected    out  4      value predicted for the next sample
// BEHAVIOUR
//  nxt(v): 0->2, 2->5, 5->3, 3->6, 6->8, 8->4, 4->1, 1->9, 9->13, 13->12, 12->0.
//  nxt(v) is 0 for any other v (7,10,11,14,15), matching the counter's recovery.
//  member(v) = v is one of the 11 cycle values.
//  Reset (reset==0): state=HUNT, expected=0, match_cnt=0, miss_cnt=0.
//  Reset also clears locked, seq_err, err_count and lap_count to 0.
//  Reset takes priority over en and over every in-flight state.
//  All outputs are registered.
//  A sample taken at edge N is reflected at edge N, visible the cycle after en was high.
//  en==0: all state holds and seq_err=0.
//  FSM, evaluated only when en==1:
//   HUNT:
//    - member(count_in): go to SYNC, expected<=nxt(count_in), match_cnt<=1.
//    - otherwise: stay in HUNT, expected<=0.
//   SYNC:
//    - count_in==expected: expected<=nxt(count_in), match_cnt++.
//    - if match_cnt+1==LOCK_N: go to LOCKED, miss_cnt<=0.
//    - mismatch with member(count_in): restart SYNC, match_cnt<=1, expected<=nxt(count_in).
//    - mismatch with non-member: go to HUNT, expected<=0.
//    - SYNC never asserts seq_err or touches err_count.
//   LOCKED:
//    - match: expected<=nxt(count_in), miss_cnt<=0.
//    - match with count_in==12: lap_count++ (saturating).
//    - mismatch: seq_err<=1, err_count++ (saturating), miss_cnt++.
//    - mismatch: expected<=nxt(count_in), so the checker resyncs to the counter's actual path.
//    - if miss_cnt+1==UNLOCK_N: go to HUNT, expected<=0, match_cnt<=0.
//  LOCK_N==1 is legal: lock on the first member sample.
//  UNLOCK_N==1 is legal: a single miss unlocks.
//  Counters hold at all-ones and never wrap.
//  Errors after saturation still pulse seq_err.
//  locked is derived from the registered state (no combinational path from count_in).
// TESTING
//  T1 reset: reset=0 for 2 clk with en=1 and count_in=5.
//     -> locked=0, seq_err=0, err_count=0, lap_count=0, expected=0.
//  T2 lock: release reset, feed 0,2,5 with en=1.
//     -> locked=1 after the 3rd sample, expected=3, no seq_err.
//  T3 laps: feed the full 11-value cycle twice while LOCKED.
//     -> lap_count=2, err_count=0.
//     -> en gaps mid-stream change nothing.
//  T4 single glitch while LOCKED: expected=6, inject 7, then 0,2.
//     -> seq_err pulses once, err_count=1.
//     -> locked stays 1 (miss_cnt cleared by the match 0), expected=5.
//  T5 unlock: inject 15 then 11 while LOCKED.
//     -> two seq_err pulses, err_count+=2, locked=0, state HUNT.
//     -> relock after 3 valid samples.
//  T6 reset mid-lock: assert reset=0 for 1 cycle while LOCKED with lap_count=4.
//     -> all outputs 0 next cycle, FSM in HUNT.
//  T6 also: ERR_W=2, force 5 mismatches -> err_count saturates at 3.

Source files
------------

// File: rtl/random_seq_checker.sv
// Monitors the 4-bit random sequence counter, locks onto its 11-value cycle
// and reports deviations, error totals and completed laps.
module random_seq_checker #(
    parameter int LOCK_N   = 3,
    parameter int UNLOCK_N = 2,
    parameter int ERR_W    = 8,
    parameter int LAP_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       count_in,
    output logic             locked,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count,
    output logic [LAP_W-1:0] lap_count,
    output logic [3:0]       expected
);

    localparam int MW = (LOCK_N   < 2) ? 1 : $clog2(LOCK_N + 1);
    localparam int UW = (UNLOCK_N < 2) ? 1 : $clog2(UNLOCK_N + 1);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t           state_reg;
    logic [3:0]       expected_reg;
    logic [MW-1:0]    match_cnt_reg;
    logic [UW-1:0]    miss_cnt_reg;
    logic             seq_err_reg;
    logic [ERR_W-1:0] err_count_reg;
    logic [LAP_W-1:0] lap_count_reg;

    // Out-of-cycle values map to 0, mirroring the counter's own recovery path.
    function automatic logic [3:0] nxt(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            4'd0:    r = 4'd2;
            4'd2:    r = 4'd5;
            4'd5:    r = 4'd3;
            4'd3:    r = 4'd6;
            4'd6:    r = 4'd8;
            4'd8:    r = 4'd4;
            4'd4:    r = 4'd1;
            4'd1:    r = 4'd9;
            4'd9:    r = 4'd13;
            4'd13:   r = 4'd12;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic logic member(input logic [3:0] v);
        logic r;
        case (v)
            4'd7, 4'd10, 4'd11, 4'd14, 4'd15: r = 1'b0;
            default:                          r = 1'b1;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= HUNT;
            expected_reg  <= 4'd0;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
            seq_err_reg   <= 1'b0;
            err_count_reg <= '0;
            lap_count_reg <= '0;
        end else begin
            seq_err_reg <= 1'b0;
            if (en) begin
                case (state_reg)
                    HUNT: begin
                        if (member(count_in)) begin
                            expected_reg  <= nxt(count_in);
                            match_cnt_reg <= MW'(1);
                            miss_cnt_reg  <= '0;
                            state_reg     <= (LOCK_N <= 1) ? LOCKED : SYNC;
                        end else begin
                            expected_reg <= 4'd0;
                        end
                    end
                    SYNC: begin
                        if (count_in == expected_reg) begin
                            expected_reg  <= nxt(count_in);
                            match_cnt_reg <= match_cnt_reg + MW'(1);
                            if (int'(match_cnt_reg) + 1 >= LOCK_N) begin
                                state_reg    <= LOCKED;
                                miss_cnt_reg <= '0;
                            end
                        end else if (member(count_in)) begin
                            match_cnt_reg <= MW'(1);
                            expected_reg  <= nxt(count_in);
                        end else begin
                            state_reg     <= HUNT;
                            expected_reg  <= 4'd0;
                            match_cnt_reg <= '0;
                        end
                    end
                    LOCKED: begin
                        if (count_in == expected_reg) begin
                            expected_reg <= nxt(count_in);
                            miss_cnt_reg <= '0;
                            if (count_in == 4'd12 && lap_count_reg != '1)
                                lap_count_reg <= lap_count_reg + LAP_W'(1);
                        end else begin
                            seq_err_reg <= 1'b1;
                            if (err_count_reg != '1)
                                err_count_reg <= err_count_reg + ERR_W'(1);
                            if (int'(miss_cnt_reg) + 1 >= UNLOCK_N) begin
                                state_reg     <= HUNT;
                                expected_reg  <= 4'd0;
                                match_cnt_reg <= '0;
                                miss_cnt_reg  <= '0;
                            end else begin
                                miss_cnt_reg <= miss_cnt_reg + UW'(1);
                                expected_reg <= nxt(count_in);
                            end
                        end
                    end
                    default: begin
                        state_reg    <= HUNT;
                        expected_reg <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign locked    = (state_reg == LOCKED);
    assign seq_err   = seq_err_reg;
    assign err_count = err_count_reg;
    assign lap_count = lap_count_reg;
    assign expected  = expected_reg;

endmodule

// File: tb/tb_random_seq_checker.sv
// Directed bench for random_seq_checker: reference model feeds a scoreboard queue,
// plus a second instance with a narrow error counter for saturation.
module tb_random_seq_checker;

    logic        clk = 1'b0;
    logic        reset, en;
    logic [3:0]  count_in;
    logic        locked, seq_err;
    logic [7:0]  err_count;
    logic [15:0] lap_count;
    logic [3:0]  expected;

    logic        reset2, en2;
    logic [3:0]  cin2;
    logic        locked2, seq_err2;
    logic [1:0]  err2;
    logic [15:0] lap2;
    logic [3:0]  exp2;

    always #5 clk = ~clk;

    random_seq_checker #(.LOCK_N(3), .UNLOCK_N(2), .ERR_W(8), .LAP_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .count_in(count_in),
        .locked(locked), .seq_err(seq_err), .err_count(err_count),
        .lap_count(lap_count), .expected(expected)
    );

    random_seq_checker #(.LOCK_N(1), .UNLOCK_N(8), .ERR_W(2), .LAP_W(16)) dut_sat (
        .clk(clk), .reset(reset2), .en(en2), .count_in(cin2),
        .locked(locked2), .seq_err(seq_err2), .err_count(err2),
        .lap_count(lap2), .expected(exp2)
    );

    localparam logic [3:0] CYC [11] = '{4'd0, 4'd2, 4'd5, 4'd3, 4'd6, 4'd8,
                                         4'd4, 4'd1, 4'd9, 4'd13, 4'd12};

    typedef struct {
        logic        locked;
        logic        seq_err;
        logic [7:0]  err;
        logic [15:0] lap;
        logic [3:0]  exp;
    } out_t;

    out_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;

    // Reference model state (0=HUNT, 1=SYNC, 2=LOCKED)
    int          m_state = 0;
    logic [3:0]  m_exp = 0;
    int          m_match = 0;
    int          m_miss = 0;
    logic [7:0]  m_err = 0;
    logic [15:0] m_lap = 0;
    logic        m_seqerr = 0;

    function automatic logic [3:0] succ(input logic [3:0] v);
        for (int i = 0; i < 11; i++)
            if (CYC[i] == v) return CYC[(i + 1) % 11];
        return 4'd0;
    endfunction

    function automatic logic in_cycle(input logic [3:0] v);
        for (int i = 0; i < 11; i++)
            if (CYC[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic [3:0] v);
        if (!r) begin
            m_state = 0; m_exp = 0; m_match = 0; m_miss = 0;
            m_err = 0; m_lap = 0; m_seqerr = 0;
            return;
        end
        m_seqerr = 0;
        if (!e) return;
        if (m_state == 0) begin
            if (in_cycle(v)) begin
                m_state = 1; m_exp = succ(v); m_match = 1;
            end else m_exp = 0;
        end else if (m_state == 1) begin
            if (v == m_exp) begin
                m_match++; m_exp = succ(v);
                if (m_match == 3) begin m_state = 2; m_miss = 0; end
            end else if (in_cycle(v)) begin
                m_match = 1; m_exp = succ(v);
            end else begin
                m_state = 0; m_exp = 0; m_match = 0;
            end
        end else begin
            if (v == m_exp) begin
                m_exp = succ(v); m_miss = 0;
                if (v == 4'd12 && m_lap != 16'hFFFF) m_lap++;
            end else begin
                m_seqerr = 1;
                if (m_err != 8'hFF) m_err++;
                m_miss++;
                if (m_miss == 2) begin
                    m_state = 0; m_exp = 0; m_match = 0; m_miss = 0;
                end else m_exp = succ(v);
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] v);
        out_t want, got;
        reset = r; en = e; count_in = v;
        model_step(r, e, v);
        want.locked = (m_state == 2); want.seq_err = m_seqerr;
        want.err = m_err; want.lap = m_lap; want.exp = m_exp;
        sb_q.push_back(want);
        @(posedge clk); #1;
        got = sb_q.pop_front();
        chk($sformatf("locked[v=%0d]", v),    locked,    got.locked);
        chk($sformatf("seq_err[v=%0d]", v),   seq_err,   got.seq_err);
        chk($sformatf("err_count[v=%0d]", v), err_count, got.err);
        chk($sformatf("lap_count[v=%0d]", v), lap_count, got.lap);
        chk($sformatf("expected[v=%0d]", v),  expected,  got.exp);
        if (seq_err) pulses++;
        $display("step reset=%0b en=%0b in=%0d -> locked=%0b seq_err=%0b err=%0d lap=%0d exp=%0d",
                 r, e, v, locked, seq_err, err_count, lap_count, expected);
    endtask

    task automatic step2(input logic r, input logic e, input logic [3:0] v);
        reset2 = r; en2 = e; cin2 = v;
        @(posedge clk); #1;
        $display("sat reset=%0b en=%0b in=%0d -> locked=%0b seq_err=%0b err=%0d exp=%0d",
                 r, e, v, locked2, seq_err2, err2, exp2);
    endtask

    task automatic feed_laps(input int n, input bit gaps);
        for (int l = 0; l < n; l++)
            for (int i = 0; i < 11; i++) begin
                if (gaps && i == 5) begin
                    step(1'b1, 1'b0, 4'($urandom_range(15)));
                    step(1'b1, 1'b0, 4'($urandom_range(15)));
                end
                step(1'b1, 1'b1, CYC[(3 + i) % 11]);
            end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; count_in = 4'd0;
        reset2 = 1'b0; en2 = 1'b0; cin2 = 4'd0;

        // T1 reset
        step(1'b0, 1'b1, 4'd5);
        step(1'b0, 1'b1, 4'd5);
        chk("t1_locked", locked, 0);
        chk("t1_expected", expected, 0);

        // T2 lock
        step(1'b1, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'd2);
        chk("t2_not_yet_locked", locked, 0);
        step(1'b1, 1'b1, 4'd5);
        chk("t2_locked", locked, 1);
        chk("t2_expected", expected, 3);
        chk("t2_pulses", pulses, 0);

        // T3 two laps with en gaps
        feed_laps(2, 1'b1);
        chk("t3_laps", lap_count, 2);
        chk("t3_errs", err_count, 0);
        chk("t3_expected", expected, 3);

        // T4 single glitch
        step(1'b1, 1'b1, 4'd3);
        chk("t4_expected6", expected, 6);
        pulses = 0;
        step(1'b1, 1'b1, 4'd7);
        step(1'b1, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'd2);
        chk("t4_pulses", pulses, 1);
        chk("t4_errs", err_count, 1);
        chk("t4_locked", locked, 1);
        chk("t4_expected", expected, 5);

        // T5 unlock then relock
        pulses = 0;
        step(1'b1, 1'b1, 4'd15);
        step(1'b1, 1'b1, 4'd11);
        chk("t5_pulses", pulses, 2);
        chk("t5_errs", err_count, 3);
        chk("t5_unlocked", locked, 0);
        step(1'b1, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'd2);
        step(1'b1, 1'b1, 4'd5);
        chk("t5_relocked", locked, 1);

        // T6 reset while locked with lap_count=4
        feed_laps(2, 1'b0);
        chk("t6_laps", lap_count, 4);
        step(1'b0, 1'b1, 4'd3);
        chk("t6_locked", locked, 0);
        chk("t6_laps_cleared", lap_count, 0);
        chk("t6_errs_cleared", err_count, 0);
        chk("t6_expected", expected, 0);
        step(1'b1, 1'b1, 4'd3);
        chk("t6_hunt_to_sync", locked, 0);

        // Narrow error counter saturation, LOCK_N=1
        step2(1'b0, 1'b1, 4'd0);
        chk("sat_reset_err", err2, 0);
        step2(1'b1, 1'b1, 4'd0);
        chk("sat_lock1", locked2, 1);
        chk("sat_exp", exp2, 2);
        for (int k = 0; k < 5; k++) begin
            step2(1'b1, 1'b1, 4'd7);
            chk($sformatf("sat_pulse%0d", k), seq_err2, 1);
            chk($sformatf("sat_err%0d", k), err2, (k + 1 > 3) ? 3 : k + 1);
        end
        step2(1'b1, 1'b0, 4'd7);
        chk("sat_hold_pulse", seq_err2, 0);
        chk("sat_hold_err", err2, 3);
        chk("sat_still_locked", locked2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
